// File: rtl/axil_ctrl_regs.sv
// AXI4-Lite control/status register file for the accelerator's global controller.
// Optional cycle counter at 0x14 is built only when PERF_CNT_EN is defined.
module axil_ctrl_regs #(
  parameter int          ADDR_W    = 6,
  parameter logic [31:0] K_DIM_RST = 32'd192
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [31:0]       s_wdata,
  input  logic [3:0]        s_wstrb,
  input  logic              s_wvalid,
  output logic              s_wready,
  output logic [1:0]        s_bresp,
  output logic              s_bvalid,
  input  logic              s_bready,
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [31:0]       s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic              ap_start,
  output logic [31:0]       cfg_k_dim,
  input  logic              ap_done,
  input  logic              ap_idle,
  input  logic [2:0]        state_dbg,
  output logic              irq
);

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_GIE    = 3'd1;
  localparam logic [2:0] REG_IER    = 3'd2;
  localparam logic [2:0] REG_ISR    = 3'd3;
  localparam logic [2:0] REG_KDIM   = 3'd4;
  localparam logic [2:0] REG_CYCLES = 3'd5;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Write-channel holders
  logic        aw_held;
  logic [2:0]  aw_idx_q;
  logic        w_held;
  logic [31:0] w_data_q;
  logic [3:0]  w_strb_q;

  // Register state
  logic        start_flag;
  logic        done_flag;
  logic        done_q;
  logic        gie;
  logic        ier;
  logic        isr;
  logic [31:0] k_dim;
  logic [31:0] cycles_val;

  logic        aw_hs;
  logic        w_hs;
  logic        ar_hs;
  logic        wr_fire;
  logic [2:0]  wr_idx;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic [2:0]  rd_idx;
  logic        done_rise;
  logic        start_set;
  logic        kdim_we;

  logic        unused_addr;
  assign unused_addr = ^{s_awaddr, s_araddr};

  assign s_awready = ~aw_held & ~s_bvalid;
  assign s_wready  = ~w_held & ~s_bvalid;
  assign s_arready = ~s_rvalid;

  assign aw_hs = s_awvalid & s_awready;
  assign w_hs  = s_wvalid & s_wready;
  assign ar_hs = s_arvalid & s_arready;

  // A beat arriving this cycle is used directly, so a write can retire in its handshake cycle.
  assign wr_fire = (aw_held | aw_hs) & (w_held | w_hs);
  assign wr_idx  = aw_held ? aw_idx_q : s_awaddr[4:2];
  assign wr_data = w_held ? w_data_q : s_wdata;
  assign wr_strb = w_held ? w_strb_q : s_wstrb;
  assign rd_idx  = s_araddr[4:2];

  assign done_rise = ap_done & ~done_q;
  assign start_set = wr_fire && (wr_idx == REG_CTRL) && wr_strb[0] && wr_data[0]
                     && ap_idle && !start_flag;
  assign kdim_we   = wr_fire && (wr_idx == REG_KDIM) && !start_flag && ap_idle;

  assign ap_start  = start_flag;
  assign cfg_k_dim = k_dim;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_held  <= 1'b0;
      aw_idx_q <= '0;
      w_held   <= 1'b0;
      w_data_q <= '0;
      w_strb_q <= '0;
      s_bvalid <= 1'b0;
      s_bresp  <= RESP_OKAY;
    end else begin
      if (wr_fire) begin
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
        s_bvalid <= 1'b1;
        s_bresp  <= (wr_idx <= REG_CYCLES) ? RESP_OKAY : RESP_SLVERR;
      end else begin
        if (aw_hs) begin
          aw_held  <= 1'b1;
          aw_idx_q <= s_awaddr[4:2];
        end
        if (w_hs) begin
          w_held   <= 1'b1;
          w_data_q <= s_wdata;
          w_strb_q <= s_wstrb;
        end
        if (s_bvalid && s_bready) s_bvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_flag <= 1'b0;
      done_flag  <= 1'b0;
      done_q     <= 1'b0;
      gie        <= 1'b0;
      ier        <= 1'b0;
      isr        <= 1'b0;
      k_dim      <= K_DIM_RST;
      irq        <= 1'b0;
    end else begin
      done_q <= ap_done;
      // Dropping start while done is high lets the controller leave DONE for IDLE.
      if (ap_done)        start_flag <= 1'b0;
      else if (start_set) start_flag <= 1'b1;

      if (done_rise)                    done_flag <= 1'b1;
      else if (ar_hs && rd_idx == REG_CTRL) done_flag <= 1'b0;

      if (done_rise) isr <= 1'b1;
      else if (wr_fire && wr_idx == REG_ISR && wr_strb[0] && wr_data[0]) isr <= 1'b0;

      if (wr_fire && wr_idx == REG_GIE && wr_strb[0]) gie <= wr_data[0];
      if (wr_fire && wr_idx == REG_IER && wr_strb[0]) ier <= wr_data[0];

      for (int b = 0; b < 4; b++) begin
        if (kdim_we && wr_strb[b]) k_dim[8*b +: 8] <= wr_data[8*b +: 8];
      end

      irq <= gie & ier & isr;
    end
  end

`ifdef PERF_CNT_EN
  logic        start_q;
  logic [31:0] cycles;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= 1'b0;
      cycles  <= '0;
    end else begin
      start_q <= start_flag;
      // The rising cycle itself counts, so the value equals cycles spent with start high and done low.
      if (start_flag && !start_q)
        cycles <= ap_done ? 32'd0 : 32'd1;
      else if (start_flag && !ap_done && cycles != 32'hFFFF_FFFF)
        cycles <= cycles + 32'd1;
    end
  end

  assign cycles_val = cycles;
`else
  assign cycles_val = '0;
`endif

  logic [31:0] rd_val;
  logic        rd_err;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    rd_val = '0;
    rd_err = 1'b0;
    case (rd_idx)
      REG_CTRL:   rd_val = {26'd0, state_dbg, ap_idle, done_flag, start_flag};
      REG_GIE:    rd_val = {31'd0, gie};
      REG_IER:    rd_val = {31'd0, ier};
      REG_ISR:    rd_val = {31'd0, isr};
      REG_KDIM:   rd_val = k_dim;
      REG_CYCLES: rd_val = cycles_val;
      default:    rd_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_rvalid <= 1'b0;
      s_rdata  <= '0;
      s_rresp  <= RESP_OKAY;
    end else if (ar_hs) begin
      s_rvalid <= 1'b1;
      s_rdata  <= rd_val;
      s_rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
    end else if (s_rvalid && s_rready) begin
      s_rvalid <= 1'b0;
    end
  end

endmodule

// File: doc/axil_ctrl_regs.md
Name: axil_ctrl_regs

Overview:
- AXI4-Lite slave register file that gives the PS (CPU) control of the accelerator.
- Drives the global controller's `ap_start` and `cfg_k_dim` inputs.
- Samples its `ap_done`, `ap_idle` and `current_state_dbg` outputs into status registers, and raises a level interrupt to the PS on completion.
- Sits between the Zynq AXI GP port and the global controller. It is the CPU-facing end of the start/done handshake.

Parameters:
- ADDR_W, 6, byte-address width of the AXI-Lite port; only bits [4:2] are decoded.
- K_DIM_RST, 192, reset value of the K_DIM register.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- s_awaddr  in  ADDR_W  write address
- s_awvalid  in  1  write address valid
- s_awready  out  1  write address ready
- s_wdata  in  32  write data
- s_wstrb  in  4  write byte strobes
- s_wvalid  in  1  write data valid
- s_wready  out  1  write data ready
- s_bresp  out  2  write response
- s_bvalid  out  1  write response valid
- s_bready  in  1  write response ready
- s_araddr  in  ADDR_W  read address
- s_arvalid  in  1  read address valid
- s_arready  out  1  read address ready
- s_rdata  out  32  read data
- s_rresp  out  2  read response
- s_rvalid  out  1  read data valid
- s_rready  in  1  read data ready
- ap_start  out  1  level start to the controller
- cfg_k_dim  out  32  K dimension to the controller
- ap_done  in  1  done from the controller (high for the DONE state plus 1 cycle)
- ap_idle  in  1  idle from the controller
- state_dbg  in  3  controller state code
- irq  out  1  level interrupt to the PS

Behaviour:
- Reset: all outputs 0, except cfg_k_dim=K_DIM_RST. All internal registers 0 (K_DIM=K_DIM_RST). Reset asserted mid-transaction aborts it; no response is issued after reset.
- Register map (byte offset):
  - 0x00 CTRL:
    - [0] START: write-1-sets; reads the start flag.
    - [1] DONE: sticky; clear-on-read.
    - [2] IDLE: live `ap_idle`.
    - [5:3] live `state_dbg`.
    - Other bits read 0.
  - 0x04 GIE: [0] global interrupt enable, RW.
  - 0x08 IER: [0] done interrupt enable, RW.
  - 0x0C ISR: [0] done status; write-1-clears.
  - 0x10 K_DIM: 32-bit RW; honours wstrb per byte.
  - 0x14 CYCLES: RO; see Optional Feature.
  - 0x18, 0x1C: unmapped.
- Write channel:
  - AW and W are captured independently. awready=1 while no address is held and bvalid=0; wready=1 likewise for data.
  - The register update occurs in the cycle both are held. bvalid rises the next cycle and holds until bready; the holders then clear.
  - Maximum throughput: one write per 2 cycles.
- Read channel:
  - arready=1 when rvalid=0.
  - rdata/rvalid are registered: 1-cycle latency from the AR handshake. rvalid holds until rready, and rdata stays stable while held.
- Responses: bresp/rresp = 2'b00 for mapped offsets; 2'b10 (SLVERR) for unmapped offsets. Unmapped reads return 0; unmapped writes have no effect.
- Start handshake:
  - Writing CTRL[0]=1 sets the start flag only if `ap_idle`=1 and the flag is 0. Otherwise the write is ignored, still with OKAY.
  - `ap_start` = start flag.
  - The flag clears in the cycle after `ap_done` is sampled high. The controller therefore sees `ap_start` low while in DONE and returns to IDLE.
- K_DIM writes are ignored while `ap_start`=1 or `ap_idle`=0 (OKAY response). cfg_k_dim = K_DIM register.
- Done capture:
  - Rising edge of `ap_done` (registered 1-cycle delay edge detect) sets CTRL.DONE and ISR[0].
  - A CTRL read returns DONE=1 and clears it on the AR handshake.
  - If a set and a clear hit DONE or ISR[0] in the same cycle, the set wins.
- irq = GIE[0] & IER[0] & ISR[0], registered, 1-cycle latency.
- Simultaneous read and write to the same register: the read returns the pre-write value.

Optional Feature:
- Macro: PERF_CNT_EN.
- Defined:
  - CYCLES is a 32-bit counter. It clears on the cycle `ap_start` rises and increments every cycle while `ap_start`=1 and `ap_done`=0.
  - It freezes at done, holds its value until the next start, and saturates at 0xFFFFFFFF.
  - 0x14 reads the counter with OKAY.
- Undefined: no counter logic. 0x14 reads 0 with OKAY; writes are ignored.

Test Plan:
- Reset defaults: after reset, read 0x10 -> 0x000000C0. Read 0x00 with ap_idle=1, state_dbg=0 -> 0x00000004; irq=0, ap_start=0.
- Write channel order: write 0x10=0x00000100, once with AW before W by 3 cycles and once with W before AW -> both give bresp=OKAY and cfg_k_dim=256. Hold bready=0 for 5 cycles -> bvalid stays high.
- Full run: set GIE=1, IER=1, write CTRL=0x1 -> ap_start=1. Drive ap_idle=0, then ap_done=1 for 2 cycles -> ap_start falls, ISR=1, irq=1. First CTRL read has bit1=1; second read has bit1=0. Write ISR=0x1 -> irq=0.
- Busy protection: while ap_idle=0, write K_DIM=0x40 and write CTRL=0x1 again -> cfg_k_dim unchanged, no extra start, both OKAY.
- Errors and strobes: read 0x18 -> rdata=0, rresp=2'b10. Write K_DIM=0xAABBCCDD with wstrb=4'b0010 -> K_DIM=0x0000CC00 when starting from 0.
- PERF_CNT_EN: start, then assert ap_done exactly 100 cycles after ap_start rises -> CYCLES reads 100. Without the macro, CYCLES reads 0.
